// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch (i_*) and data (d_*)
// requesters, with one transaction outstanding and a timeout abort.
// Ports:
//   clk, rst_n                             clock, async active-low reset
//   i_req/i_addr -> i_gnt/i_rvalid/i_rdata/i_err              fetch side
//   d_req/d_we/d_addr/d_wdata/d_be -> d_gnt/d_rvalid/d_rdata/d_err
//   m_req/m_we/m_addr/m_wdata/m_be <- m_ack/m_rdata          memory side
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int MAX_D_STREAK = 2,
   parameter int TIMEOUT      = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [31:0]       i_rdata,
   output logic              i_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [3:0]        d_be,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   output logic [3:0]        m_be,
   input  logic              m_ack,
   input  logic [31:0]       m_rdata
);

   localparam logic [7:0] STREAK_MAX = 8'(MAX_D_STREAK);
   localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t     state;
   state_t     state_n;
   logic [7:0] wait_cnt;
   logic [7:0] streak;
   logic       pick_i;
   logic       pick_d;
   logic       done;
   logic       abort;
   logic       at_max;
   logic       busy;
   logic       busy_i;
   logic       busy_d;
   logic       finish;

   assign at_max = (streak == STREAK_MAX);
   assign busy   = (state != IDLE);
   assign busy_i = (state == BUSY_I);
   assign busy_d = (state == BUSY_D);
   assign finish = done | abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Data wins unless fetch has already waited out MAX_D_STREAK
   // data grants. An ack in the last allowed cycle beats the timeout.
   always_comb begin
      state_n = state;
      pick_i  = 1'b0;
      pick_d  = 1'b0;
      done    = 1'b0;
      abort   = 1'b0;
      unique case (state)
         IDLE: begin
            if (d_req && !(i_req && at_max)) begin
               pick_d  = 1'b1;
               state_n = BUSY_D;
            end else if (i_req) begin
               pick_i  = 1'b1;
               state_n = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (m_ack) begin
               done    = 1'b1;
               state_n = IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
               abort   = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_gnt    <= 1'b0;
         d_gnt    <= 1'b0;
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         i_err    <= 1'b0;
         d_err    <= 1'b0;
         i_rdata  <= '0;
         d_rdata  <= '0;
         m_req    <= 1'b0;
         m_we     <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
         m_be     <= '0;
         wait_cnt <= '0;
         streak   <= '0;
      end else begin
         i_gnt    <= pick_i;
         d_gnt    <= pick_d;
         i_rvalid <= finish & busy_i;
         d_rvalid <= finish & busy_d;
         i_err    <= abort & busy_i;
         d_err    <= abort & busy_d;
         if (finish && busy_i) i_rdata <= done ? m_rdata : '0;
         if (finish && busy_d) d_rdata <= done ? m_rdata : '0;
         if (pick_i || pick_d) begin
            m_req    <= 1'b1;
            m_we     <= pick_d & d_we;
            m_addr   <= pick_d ? d_addr : i_addr;
            m_wdata  <= pick_d ? d_wdata : '0;
            m_be     <= pick_d ? d_be : 4'hF;
            wait_cnt <= '0;
         end else if (finish) begin
            m_req    <= 1'b0;
         end else if (busy) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         // Streak counts data grants that made a waiting fetch wait.
         if (pick_i) begin
            streak <= '0;
         end else if (pick_d && i_req) begin
            if (!at_max) streak <= streak + 8'd1;
         end else if (!busy && !i_req) begin
            streak <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by random traffic, all
// checked each cycle against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int TO   = 4;
   localparam int MAXS = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_gnt, i_rvalid, i_err;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_be = '0;
   logic        d_gnt, d_rvalid, d_err;
   logic [31:0] d_rdata;
   logic        m_req, m_we;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_be;
   logic        m_ack = 1'b0;
   logic [31:0] m_rdata = '0;

   int errors = 0;
   int checks = 0;

   mem_arbiter #(
      .ADDR_W(32), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
      .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_be(d_be), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_be(m_be),
      .m_ack(m_ack), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   // Reference model: one pending transaction record plus a count of
   // data grants that overtook a waiting fetch.
   bit          p_v, p_d;
   int          p_age;
   int          streak;
   bit          e_ig, e_dg, e_ir, e_dr, e_ie, e_de, e_mreq, e_mwe;
   logic [31:0] e_ird, e_drd, e_maddr, e_mwd;
   logic [3:0]  e_mbe;

   task automatic model_reset();
      p_v = 0; p_d = 0; p_age = 0; streak = 0;
      e_ig = 0; e_dg = 0; e_ir = 0; e_dr = 0; e_ie = 0; e_de = 0;
      e_mreq = 0; e_mwe = 0;
      e_ird = '0; e_drd = '0; e_maddr = '0; e_mwd = '0; e_mbe = '0;
   endtask

   task automatic model_step();
      bit take_d;
      if (!rst_n) begin
         model_reset();
         return;
      end
      e_ig = 0; e_dg = 0; e_ir = 0; e_dr = 0; e_ie = 0; e_de = 0;
      if (p_v) begin
         if (m_ack) begin
            p_v = 0;
            if (p_d) begin e_dr = 1; e_drd = m_rdata; end
            else     begin e_ir = 1; e_ird = m_rdata; end
         end else begin
            p_age++;
            if (p_age == TO) begin
               p_v = 0;
               if (p_d) begin e_dr = 1; e_de = 1; e_drd = '0; end
               else     begin e_ir = 1; e_ie = 1; e_ird = '0; end
            end
         end
      end else begin
         take_d = d_req && !(i_req && streak == MAXS);
         if (take_d || i_req) begin
            p_v = 1; p_d = take_d; p_age = 0;
            e_dg = take_d; e_ig = !take_d;
            e_mwe = take_d && d_we;
            e_maddr = take_d ? d_addr : i_addr;
            e_mwd = take_d ? d_wdata : '0;
            e_mbe = take_d ? d_be : 4'hF;
         end
         if (!i_req)      streak = 0;
         else if (take_d) streak = (streak < MAXS) ? streak + 1 : MAXS;
         else             streak = 0;
      end
      e_mreq = p_v;
   endtask

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("i_gnt", 64'(i_gnt), 64'(e_ig));
      chk("d_gnt", 64'(d_gnt), 64'(e_dg));
      chk("i_rvalid", 64'(i_rvalid), 64'(e_ir));
      chk("d_rvalid", 64'(d_rvalid), 64'(e_dr));
      chk("m_req", 64'(m_req), 64'(e_mreq));
      if (e_ir) begin
         chk("i_err", 64'(i_err), 64'(e_ie));
         chk("i_rdata", 64'(i_rdata), 64'(e_ird));
      end
      if (e_dr) begin
         chk("d_err", 64'(d_err), 64'(e_de));
         chk("d_rdata", 64'(d_rdata), 64'(e_drd));
      end
      if (e_mreq) begin
         chk("m_we", 64'(m_we), 64'(e_mwe));
         chk("m_addr", 64'(m_addr), 64'(e_maddr));
         chk("m_be", 64'(m_be), 64'(e_mbe));
         if (e_mwe) chk("m_wdata", 64'(m_wdata), 64'(e_mwd));
      end
      if (!rst_n) begin
         chk("rst_i_rdata", 64'(i_rdata), 64'd0);
         chk("rst_d_rdata", 64'(d_rdata), 64'd0);
         chk("rst_m_addr", 64'(m_addr), 64'd0);
         chk("rst_m_misc", 64'({m_we, m_be, i_err, d_err}), 64'd0);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   initial begin
      string order;
      model_reset();
      #2 rst_n = 1'b0;
      #1 check_all();
      cyc();
      cyc();
      rst_n = 1'b1;

      // single fetch, minimum latency
      i_req = 1; i_addr = 32'h10;
      cyc();
      chk("fetch_gnt", 64'({i_gnt, m_req}), 64'b11);
      chk("fetch_maddr", 64'(m_addr), 64'h10);
      i_req = 0; m_ack = 1; m_rdata = 32'h00500093;
      cyc();
      chk("fetch_rvalid", 64'(i_rvalid), 64'd1);
      chk("fetch_rdata", 64'(i_rdata), 64'h00500093);
      chk("fetch_err", 64'(i_err), 64'd0);
      m_ack = 0;
      cyc();

      // both held, immediate ack: D,D,I,D,D,I
      i_req = 1; d_req = 1; d_we = 0; m_ack = 1;
      order = "";
      for (int k = 0; k < 20 && order.len() < 6; k++) begin
         i_addr = 32'h1000 + 32'(k * 4);
         d_addr = 32'h2000 + 32'(k * 4);
         m_rdata = $urandom;
         cyc();
         if (d_gnt) order = {order, "D"};
         if (i_gnt) order = {order, "I"};
      end
      checks++;
      assert (order == "DDIDDI") else begin
         errors++;
         $error("FAIL grant_order got=%s exp=DDIDDI", order);
      end
      i_req = 0; d_req = 0;
      cyc();
      cyc();
      m_ack = 0;
      cyc();

      // store
      d_req = 1; d_we = 1; d_addr = 32'h100;
      d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
      cyc();
      chk("st_gnt", 64'(d_gnt), 64'd1);
      chk("st_fields", 64'({m_we, m_be}), 64'({1'b1, 4'b0011}));
      chk("st_wdata", 64'(m_wdata), 64'hDEADBEEF);
      d_req = 0; d_we = 0;
      cyc();
      chk("st_hold", 64'({m_req, m_we}), 64'b11);
      m_ack = 1; m_rdata = 32'hCAFE0001;
      cyc();
      chk("st_rvalid", 64'({d_rvalid, m_req}), 64'b10);
      chk("st_rdata", 64'(d_rdata), 64'hCAFE0001);
      m_ack = 0;
      cyc();

      // timeout with no ack
      d_req = 1; d_we = 0; d_addr = 32'h300;
      cyc();
      d_req = 0;
      for (int k = 0; k < TO - 1; k++) begin
         cyc();
         chk("to_wait", 64'({m_req, d_rvalid}), 64'b10);
      end
      cyc();
      chk("to_abort", 64'({m_req, d_rvalid, d_err}), 64'b011);
      chk("to_rdata", 64'(d_rdata), 64'd0);
      cyc();

      // async reset mid fetch
      i_req = 1; i_addr = 32'h40;
      cyc();
      i_req = 0;
      cyc();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_mreq", 64'(m_req), 64'd0);
      check_all();
      cyc();
      cyc();
      rst_n = 1'b1;
      d_req = 1; d_addr = 32'h200;
      cyc();
      chk("post_rst_gnt", 64'({d_gnt, i_rvalid}), 64'b10);
      d_req = 0; m_ack = 1; m_rdata = 32'h1234;
      cyc();
      chk("post_rst_rv", 64'({d_rvalid, i_rvalid}), 64'b10);
      m_ack = 0;
      cyc();

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         if (!i_req || e_ig) begin
            i_req = ($urandom_range(0, 9) < 5);
            i_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!d_req || e_dg) begin
            d_req = ($urandom_range(0, 9) < 5);
            d_we = $urandom_range(0, 1) == 1;
            d_addr = $urandom;
            d_wdata = $urandom;
            d_be = 4'($urandom);
         end
         if (e_mreq) m_ack = ($urandom_range(0, 99) < 35);
         else        m_ack = ($urandom_range(0, 9) == 0);
         m_rdata = $urandom;
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all ports.
REQ-002 Parameter MAX_D_STREAK, default 2: consecutive data grants allowed while fetch waits.
REQ-003 Parameter TIMEOUT, default 255: cycles in a busy state without m_ack before abort; range 1..255.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port i_req  input  1  fetch request; held with i_addr until i_gnt.
REQ-007 Port i_addr  input  ADDR_W  fetch byte address.
REQ-008 Port i_gnt  output  1  one-cycle pulse; fetch request accepted.
REQ-009 Port i_rvalid  output  1  one-cycle pulse; i_rdata/i_err valid.
REQ-010 Port i_rdata  output  32  fetched instruction word.
REQ-011 Port i_err  output  1  fetch aborted by timeout; qualified by i_rvalid.
REQ-012 Port d_req  input  1  data request; held with d_we/d_addr/d_wdata/d_be until d_gnt.
REQ-013 Port d_we  input  1  1 = store, 0 = load.
REQ-014 Port d_addr  input  ADDR_W  data byte address.
REQ-015 Port d_wdata  input  32  store data.
REQ-016 Port d_be  input  4  store byte enables.
REQ-017 Port d_gnt, d_rvalid, d_rdata(32), d_err  output  as fetch equivalents, for the data port.
REQ-018 Port m_req  output  1  memory request; held until the m_ack cycle.
REQ-019 Port m_we, m_addr(ADDR_W), m_wdata(32), m_be(4)  output  registered copy of the granted request.
REQ-020 Port m_ack  input  1  memory completes the request this cycle; m_rdata valid.
REQ-021 Port m_rdata  input  32  memory read data.

Function
REQ-022 The block SHALL use FSM states IDLE, BUSY_I, BUSY_D; one transaction outstanding at most.
REQ-023 In IDLE with any request, it SHALL on the next edge latch the winner into m_*, set m_req=1, pulse the winner's gnt high in the following cycle and enter BUSY_I/BUSY_D.
REQ-024 Arbitration SHALL favour d_req, except it SHALL grant fetch when both request and d_streak == MAX_D_STREAK.
REQ-025 d_streak SHALL increment (saturating) on each data grant made while i_req=1, and clear on any fetch grant or any IDLE cycle with i_req=0.
REQ-026 Fetch grants SHALL drive m_we=0 and m_be=4'hF.
REQ-027 In BUSY_x with m_ack=1, the next cycle SHALL have m_req=0, x_rvalid=1, x_rdata=m_rdata as registered, x_err=0, state IDLE.
REQ-028 Minimum latency: req seen at edge N, gnt and m_req high in cycle N+1, rvalid in cycle N+2 if m_ack in N+1.
REQ-029 A new request SHALL be acceptable in the same cycle rvalid is high (back-to-back, one transaction per 2 cycles).
REQ-030 A 8-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without m_ack; reaching TIMEOUT SHALL force m_req=0, x_rvalid=1, x_err=1, x_rdata=0, state IDLE.
REQ-031 m_ack in IDLE SHALL be ignored; m_ack in the timeout cycle SHALL take precedence (normal completion).
REQ-032 Stores SHALL complete like loads; d_rdata on a store completion SHALL be m_rdata.
REQ-033 gnt and rvalid SHALL never be high for the non-granted port.

Reset
REQ-034 rst_n=0 SHALL immediately force state IDLE, all gnt/rvalid/err/m_req low, m_*/rdata zero, d_streak and wait counter zero, aborting any transaction silently.
REQ-035 After rst_n release, the first request SHALL be sampled at the first rising edge.

Verification
REQ-036 Single fetch i_addr=0x10, m_ack one cycle after m_req, m_rdata=0x00500093 -> i_gnt cycle 1, i_rvalid cycle 2, i_rdata=0x00500093, i_err=0.
REQ-037 i_req and d_req held continuously, m_ack immediate, MAX_D_STREAK=2 -> grant order D,D,I,D,D,I.
REQ-038 Store d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b0011 -> m_we=1, m_be=4'b0011, m_wdata=0xDEADBEEF until m_ack; d_rvalid next cycle.
REQ-039 m_ack never asserted, TIMEOUT=4 -> m_req drops and d_rvalid=1 with d_err=1, d_rdata=0 after 4 busy cycles.
REQ-040 rst_n low mid-BUSY_I -> m_req low asynchronously, no i_rvalid; after release new d_req served normally.
